log2_to_lin: RTL and testbench

//  Streaming log2-domain to linear-domain converter for the pseudo-softmax datapath.
//  - Consumes signed fixed-point log2 values, i.e. the negated-sum results from the log-domain adders.
//  - Emits 2^x using the Mitchell approximation (1+f)*2^i as an unsigned Q1.(OUT_WIDTH-1) probability.
//  - 2-stage valid/ready pipeline with vector framing (out_last); sits between the log-domain adder and the output serializer.

---
 rtl/softmax_pkg.sv | 16 +
 rtl/pow2_shift.sv | 59 +++++
 rtl/log2_to_lin.sv | 94 +++++++++
 tb/tb_log2_to_lin.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Constants shared by the pseudo-softmax datapath blocks
// (log-domain adder, log2_to_lin converter, output serializer).
package softmax_pkg;

    localparam int LOG_DATA_WIDTH  = 8;
    localparam int LOG_FRAC_BITS   = 4;
    localparam int PROB_WIDTH      = 8;
    localparam int VEC_LEN_DEFAULT = 4;
    localparam int PROB_ONE        = 1 << (PROB_WIDTH - 1);

    // Element counter width; a one-element vector still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pow2_shift.sv
// Combinational 2^x datapath: mantissa build, shift, round, saturate.
// POW2_ROUND_EN selects round-half-up instead of truncation.
module pow2_shift
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH = LOG_DATA_WIDTH,
    parameter int FRAC_BITS  = LOG_FRAC_BITS,
    parameter int OUT_WIDTH  = PROB_WIDTH,
    parameter int IW         = DATA_WIDTH - FRAC_BITS
) (
    input  logic signed [IW-1:0]        i,
    input  logic        [FRAC_BITS-1:0] f,
    input  logic                        pos,
    output logic        [OUT_WIDTH-1:0] data,
    output logic                        sat
);

    localparam int SW = IW + 1;
    localparam logic [OUT_WIDTH-1:0] ONE = OUT_WIDTH'(1) << (OUT_WIDTH - 1);

    logic signed [SW-1:0]        i_ext;
    logic        [SW-1:0]        sh;
    logic        [OUT_WIDTH-1:0] v;
    logic                        zero;
    logic                        big;

    // Widen before negating so the most-negative integer part cannot wrap.
    assign i_ext = SW'(i);
    assign sh    = -i_ext;
    assign v     = OUT_WIDTH'({1'b1, f}) << (OUT_WIDTH - 1 - FRAC_BITS);
    assign zero  = (i == '0) && (f == '0);

`ifdef POW2_ROUND_EN
    assign big = int'(sh) > OUT_WIDTH;
`else
    assign big = int'(sh) >= OUT_WIDTH;
`endif

    always_comb begin
        data = '0;
        sat  = 1'b0;
        if (pos) begin
            data = '1;
            sat  = 1'b1;
        end else if (zero) begin
            data = ONE;
        end else if (big) begin
            data = '0;
        end else begin
`ifdef POW2_ROUND_EN
            data = OUT_WIDTH'(({1'b0, v}
                   + ((OUT_WIDTH + 1)'(1) << (sh - SW'(1)))) >> sh);
`else
            data = v >> sh;
`endif
        end
    end

endmodule

// File: rtl/log2_to_lin.sv
// Streaming log2 -> linear converter, 2-stage valid/ready pipeline.
// Rounding mode is selected by POW2_ROUND_EN (see pow2_shift).
module log2_to_lin
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH = LOG_DATA_WIDTH,
    parameter int FRAC_BITS  = LOG_FRAC_BITS,
    parameter int OUT_WIDTH  = PROB_WIDTH,
    parameter int VEC_LEN    = VEC_LEN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_sat,
    output logic                  out_last
);

    localparam int IW = DATA_WIDTH - FRAC_BITS;
    localparam int CW = cnt_width(VEC_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(VEC_LEN - 1);

    logic                  s1_valid;
    logic signed [IW-1:0]  s1_i;
    logic [FRAC_BITS-1:0]  s1_f;
    logic                  s1_pos;
    logic                  s1_last;
    logic                  s2_valid;
    logic                  s2_free;
    logic                  in_fire;
    logic [CW-1:0]         cnt;
    logic [OUT_WIDTH-1:0]  p_data;
    logic                  p_sat;

    assign s2_free   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_free;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;

    pow2_shift #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .OUT_WIDTH  (OUT_WIDTH),
        .IW         (IW)
    ) u_pow2 (
        .i    (s1_i),
        .f    (s1_f),
        .pos  (s1_pos),
        .data (p_data),
        .sat  (p_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_i     <= '0;
            s1_f     <= '0;
            s1_pos   <= 1'b0;
            s1_last  <= 1'b0;
            s2_valid <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
            out_last <= 1'b0;
            cnt      <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    // Upper bits of x are floor(x) in two's complement.
                    s1_i    <= in_data[DATA_WIDTH-1:FRAC_BITS];
                    s1_f    <= in_data[FRAC_BITS-1:0];
                    s1_pos  <= !in_data[DATA_WIDTH-1] && (|in_data);
                    s1_last <= (cnt == CNT_LAST);
                end
            end
            if (s2_free) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= p_data;
                    out_sat  <= p_sat;
                    out_last <= s1_last;
                end
            end
            if (in_fire) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_log2_to_lin.sv
// Self-checking bench for log2_to_lin at default parameters.
module tb_log2_to_lin;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_sat;
    logic       out_last;

    log2_to_lin dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mcnt = 0;
    int lo_from = 0;
    int lo_to = 0;
    bit rnd_rdy = 1'b0;
    bit lat_chk = 1'b0;
    bit saw_stall = 1'b0;

    typedef struct {
        logic [9:0] w;
        int         acc;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] rx_q[$];

    // 2^x from the real value of x: (1+f)*2^i scaled so 1.0 = 128.
    function automatic logic [9:0] model(input logic [7:0] x, input logic last);
        int  xi;
        real ip;
        real fp;
        real r;
        xi = int'($signed(x));
        if (xi > 0) return {1'b1, last, 8'hFF};
        if (xi == 0) return {1'b0, last, 8'h80};
        ip = $floor(real'(xi) / 16.0);
        fp = real'(xi) - 16.0 * ip;
        r  = (1.0 + fp / 16.0) * (2.0 ** ip) * 128.0;
`ifdef POW2_ROUND_EN
        r = $floor(r + 0.5);
`else
        r = $floor(r);
`endif
        return {1'b0, last, 8'($rtoi(r))};
    endfunction

    always @(posedge clk) begin
        #1;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        else out_ready = !(cyc >= lo_from && cyc < lo_to);
    end

    always @(negedge clk) begin
        exp_t       e;
        logic [9:0] got;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            mcnt = 0;
        end else begin
            if (out_valid && out_ready) begin
                got = {out_sat, out_last, out_data};
                rx_q.push_back(got);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream: unexpected output %h, none required", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e.w) begin
                        errors++;
                        $display("FAIL stream: got {sat,last,data}=%h required %h", got, e.w);
                    end
                    if (lat_chk) begin
                        checks++;
                        if (cyc - e.acc != 2) begin
                            errors++;
                            $display("FAIL latency: got %0d required 2", cyc - e.acc);
                        end
                    end
                end
            end
            if (in_valid && !in_ready) saw_stall = 1'b1;
            if (in_valid && in_ready) begin
                e.w   = model(in_data, mcnt == 3);
                e.acc = cyc;
                exp_q.push_back(e);
                mcnt = (mcnt + 1) % 4;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        bit a;
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        do begin
            @(negedge clk);
            a = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!a && n < 500);
        if (!a) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d outputs missing, required 0", exp_q.size());
        end
    endtask

    task automatic expect_rx(input int k, input logic [9:0] want, input string nm);
        checks++;
        if (rx_q.size() <= k) begin
            errors++;
            $display("FAIL %s: no output %0d, required %h", nm, k, want);
        end else if (rx_q[k] !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, rx_q[k], want);
        end
    endtask

    task automatic expect_bit(input logic got, input logic want, input string nm);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b required %b", nm, got, want);
        end
    endtask

    logic [7:0] t4 [8] = '{8'h00, 8'hF0, 8'hF8, 8'hFF, 8'hE0, 8'h10, 8'hC4, 8'h80};
    logic [7:0] t6 [5] = '{8'h00, 8'hF0, 8'hF8, 8'hFF, 8'h00};

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        expect_bit(out_valid, 1'b0, "rst_out_valid");
        expect_bit(out_sat, 1'b0, "rst_out_sat");
        expect_bit(out_last, 1'b0, "rst_out_last");
        expect_bit(out_data == 8'h00, 1'b1, "rst_out_data");
        expect_bit(in_ready, 1'b1, "rst_in_ready");
        tick();
        rst_n = 1'b1;
        tick();

        lat_chk = 1'b1;
        rx_q.delete();
        send(8'h00);
        send(8'hF0);
        send(8'hF8);
        send(8'hFF);
        drain();
        lat_chk = 1'b0;
        expect_rx(0, 10'h080, "t1_zero");
        expect_rx(1, 10'h040, "t1_m1");
        expect_rx(2, 10'h060, "t1_m05");
        expect_rx(3, 10'h17C, "t1_last");

        rx_q.delete();
        send(8'hB7);
        send(8'h80);
        drain();
`ifdef POW2_ROUND_EN
        expect_rx(0, 10'h006, "t2_b7");
        expect_rx(1, 10'h001, "t2_min");
`else
        expect_rx(0, 10'h005, "t2_b7");
        expect_rx(1, 10'h000, "t2_min");
`endif

        rx_q.delete();
        send(8'h10);
        send(8'hC4);
        drain();
        expect_rx(0, 10'h2FF, "t3_sat");
        expect_rx(1, 10'h10A, "t3_after_sat");

        rx_q.delete();
        saw_stall = 1'b0;
        lo_from = cyc + 3;
        lo_to = cyc + 6;
        foreach (t4[k]) send(t4[k]);
        drain();
        lo_from = 0;
        lo_to = 0;
        expect_bit(saw_stall, 1'b1, "t4_in_ready_drop");
        expect_bit(rx_q.size() == 8, 1'b1, "t4_count");
        if (rx_q.size() == 8) begin
            expect_bit(rx_q[0][8], 1'b0, "t4_last0");
            expect_bit(rx_q[3][8], 1'b1, "t4_last3");
            expect_bit(rx_q[7][8], 1'b1, "t4_last7");
        end

        rnd_rdy = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            if ($urandom_range(0, 2) == 0) tick();
            send(8'($urandom));
        end
        drain();
        rnd_rdy = 1'b0;
        tick();

        lo_from = 0;
        lo_to = 32'h7fffffff;
        tick();
        send(8'hF0);
        send(8'hF8);
        expect_bit(out_valid, 1'b1, "t6_in_flight");
        #2;
        rst_n = 1'b0;
        #1;
        expect_bit(out_valid, 1'b0, "t6_async_valid");
        expect_bit(out_data == 8'h00, 1'b1, "t6_async_data");
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        lo_to = 0;
        tick();
        rx_q.delete();
        foreach (t6[k]) send(t6[k]);
        drain();
        expect_bit(rx_q.size() == 5, 1'b1, "t6_count");
        if (rx_q.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                expect_bit(rx_q[k][8], k == 3, "t6_frame_last");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

endmodule
